// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage.
// Owns the PC, issues one imem request per instruction, buffers the returned
// word and hands it to decode with its PC. A redirect from execute retargets
// the PC in any state; a response that is still in flight when a redirect
// lands is discarded via the drop flag.
// Optional build macro: IFU_MISALIGN_CHECK_EN. When defined, a misaligned PC
// in REQ suppresses the request and parks the stage in HOLD with
// inst_misalign=1 until a redirect arrives.
module ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            drop;     // in-flight response belongs to a stale address
  logic            mis_chk;  // REQ with a misaligned PC: no request this cycle
  logic            mis_q;    // HOLD is presenting a misalignment, not a word

  assign imem_req_addr  = pc;
  assign imem_req_valid = (state == S_REQ) && !mis_chk;
  assign inst_valid     = (state == S_HOLD);
  assign inst_misalign  = mis_q;

`ifdef IFU_MISALIGN_CHECK_EN
  assign mis_chk = (state == S_REQ) && (pc[1:0] != 2'b00);

  // Misalignment flag: raised when REQ parks on a bad PC, cleared by redirect out of HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (mis_chk && !redirect_valid) begin
      mis_q <= 1'b1;
    end else if ((state == S_HOLD) && redirect_valid) begin
      mis_q <= 1'b0;
    end
  end
`else
  assign mis_chk = 1'b0;
  assign mis_q   = 1'b0;
`endif

  // Fetch FSM: redirect wins in every state; pc always takes the redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= 32'h0;
      inst_pc <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (mis_chk) begin
            // no request goes out; present the fault unless a redirect rescues us
            if (!redirect_valid) begin
              state   <= S_HOLD;
              inst    <= 32'h0;
              inst_pc <= pc;
            end
          end else if (imem_req_ready) begin
            // request accepted; a same-cycle redirect makes its response stale
            state <= S_WAIT;
            drop  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop || redirect_valid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              state   <= S_HOLD;
              inst    <= imem_resp_data;
              inst_pc <= pc;
              pc      <= pc + XLEN'(4);
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          // a redirect revokes the held word even if decode takes it this cycle
          if (redirect_valid || (inst_ready && !mis_q)) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
